// File: rtl/gate_chk_pkg.sv
// ============================================================================
// Module   : gate_chk_pkg
// Brief    : Shared gate opcodes, checker state encoding and reference function.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gate_chk_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NAND = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_XNOR = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unknown opcodes fall back to AND so a bad parameter still yields a defined check.
    function automatic logic gate_eval(input int op, input logic a, input logic b);
        logic r;
        case (op)
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_response_checker_if.sv
// ============================================================================
// Module   : gate_response_checker_if
// Brief    : Sample/verdict bundle between a gate stimulus source and the checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface gate_response_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             smp_valid;
    logic             a;
    logic             b;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [3:0]       cov;
    logic [ERR_W-1:0] err_cnt;
    logic             first_err_vld;
    logic [2:0]       first_err_vec;

    modport master (
        output start, smp_valid, a, b, y,
        input  busy, done, pass, timeout, cov, err_cnt, first_err_vld, first_err_vec
    );

    modport slave (
        input  start, smp_valid, a, b, y,
        output busy, done, pass, timeout, cov, err_cnt, first_err_vld, first_err_vec
    );
endinterface

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ============================================================================
// Module   : gate_ref_model
// Brief    : Combinational 2-input reference gate selected by GATE_OP.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int GATE_OP = 0
) (
    input  wire  a,
    input  wire  b,
    output logic exp
);

    assign exp = gate_eval(GATE_OP, a, b);

endmodule

`default_nettype wire

// File: rtl/gate_response_checker.sv
// ============================================================================
// Module   : gate_response_checker
// Brief    : Compares sampled gate output against a reference, tracks input
//            coverage, mismatches and timeout, and issues a pass/fail verdict.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int GATE_OP = 0,
    parameter int ERR_W   = 8,
    parameter int TMO_CYC = 1024
) (
    input  wire                      clk,
    input  wire                      rst,
    gate_response_checker_if.slave   bus
);

    localparam int                 c_TMO_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cov,      w_cov_nxt;
    logic [ERR_W-1:0]   r_err_cnt,  w_err_nxt;
    logic               r_fe_vld,   w_fe_vld_nxt;
    logic [2:0]         r_fe_vec,   w_fe_vec_nxt;
    logic               r_pass,     w_pass_nxt;
    logic               r_timeout,  w_timeout_nxt;
    logic [c_TMO_W-1:0] r_tmo_cnt,  w_tmo_cnt_nxt;

    logic               w_exp;
    logic               w_mismatch;
    logic               w_expire;
    logic [3:0]         w_onehot;

    gate_ref_model #(
        .GATE_OP (GATE_OP)
    ) u_ref (
        .a   (bus.a),
        .b   (bus.b),
        .exp (w_exp)
    );

    assign w_mismatch = (bus.y != w_exp);
    assign w_onehot   = 4'b0001 << {bus.a, bus.b};
    assign w_expire   = (TMO_CYC != 0) && (r_tmo_cnt == c_TMO_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_cov_nxt     = r_cov;
        w_err_nxt     = r_err_cnt;
        w_fe_vld_nxt  = r_fe_vld;
        w_fe_vec_nxt  = r_fe_vec;
        w_pass_nxt    = r_pass;
        w_timeout_nxt = r_timeout;
        w_tmo_cnt_nxt = r_tmo_cnt;

        // start wins in every state; a sample on the same edge is discarded.
        if (bus.start) begin
            w_state_nxt   = ST_RUN;
            w_cov_nxt     = '0;
            w_err_nxt     = '0;
            w_fe_vld_nxt  = 1'b0;
            w_fe_vec_nxt  = '0;
            w_pass_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
            w_tmo_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                    if (bus.smp_valid) begin
                        w_cov_nxt = r_cov | w_onehot;
                        if (w_mismatch) begin
                            if (r_err_cnt != '1) begin
                                w_err_nxt = r_err_cnt + 1'b1;
                            end
                            if (!r_fe_vld) begin
                                w_fe_vld_nxt = 1'b1;
                                w_fe_vec_nxt = {bus.a, bus.b, bus.y};
                            end
                        end
                    end
                    // Coverage completion outranks an expiry on the same edge.
                    if (w_cov_nxt == 4'hF) begin
                        w_state_nxt = ST_DONE;
                        w_pass_nxt  = (w_err_nxt == '0);
                    end else if (w_expire) begin
                        w_state_nxt   = ST_DONE;
                        w_timeout_nxt = 1'b1;
                        w_pass_nxt    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cov     <= '0;
            r_err_cnt <= '0;
            r_fe_vld  <= 1'b0;
            r_fe_vec  <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cov     <= w_cov_nxt;
            r_err_cnt <= w_err_nxt;
            r_fe_vld  <= w_fe_vld_nxt;
            r_fe_vec  <= w_fe_vec_nxt;
            r_pass    <= w_pass_nxt;
            r_timeout <= w_timeout_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    assign bus.busy          = (r_state == ST_RUN);
    assign bus.done          = (r_state == ST_DONE);
    assign bus.pass          = r_pass;
    assign bus.timeout       = r_timeout;
    assign bus.cov           = r_cov;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.first_err_vld = r_fe_vld;
    assign bus.first_err_vec = r_fe_vec;

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
// ============================================================================
// Module   : tb_gate_response_checker
// Brief    : Directed self-checking bench: AND checker with short timeout and an
//            XOR checker with 2-bit error counter and no timeout, shared stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gate_response_checker;

    logic clk;
    logic rst;
    logic start;
    logic smp_valid;
    logic a;
    logic b;
    logic y;

    int n_chk;
    int n_err;

    gate_response_checker_if #(.ERR_W(8)) if0 ();
    gate_response_checker_if #(.ERR_W(2)) if1 ();

    assign if0.start     = start;
    assign if0.smp_valid = smp_valid;
    assign if0.a         = a;
    assign if0.b         = b;
    assign if0.y         = y;

    // Second checker always sees an inverted XOR gate.
    assign if1.start     = start;
    assign if1.smp_valid = smp_valid;
    assign if1.a         = a;
    assign if1.b         = b;
    assign if1.y         = ~(a ^ b);

    gate_response_checker #(
        .GATE_OP (0),
        .ERR_W   (8),
        .TMO_CYC (16)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    gate_response_checker #(
        .GATE_OP (2),
        .ERR_W   (2),
        .TMO_CYC (0)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic smp(input logic ia, input logic ib, input logic iy);
        a         = ia;
        b         = ib;
        y         = iy;
        smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b0;
        start     = 1'b0;
        smp_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        y         = 1'b0;
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy",  32'(if0.busy), 32'd0);
        chk("rst_done",  32'(if0.done), 32'd0);
        chk("rst_pass",  32'(if0.pass), 32'd0);
        chk("rst_cov",   32'(if0.cov), 32'd0);
        chk("rst_err",   32'(if0.err_cnt), 32'd0);
        chk("rst_fvld",  32'(if0.first_err_vld), 32'd0);

        // Idle ignores samples
        smp(1'b1, 1'b1, 1'b0);
        chk("idle_cov", 32'(if0.cov), 32'd0);
        chk("idle_err", 32'(if0.err_cnt), 32'd0);

        // Clean AND sweep
        pulse_start();
        chk("t1_busy", 32'(if0.busy), 32'd1);
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        smp(1'b1, 1'b0, 1'b0);
        chk("t1_busy3", 32'(if0.busy), 32'd1);
        chk("t1_cov3",  32'(if0.cov), 32'h7);
        smp(1'b1, 1'b1, 1'b1);
        chk("t1_done",  32'(if0.done), 32'd1);
        chk("t1_busy",  32'(if0.busy), 32'd0);
        chk("t1_pass",  32'(if0.pass), 32'd1);
        chk("t1_cov",   32'(if0.cov), 32'hF);
        chk("t1_err",   32'(if0.err_cnt), 32'd0);
        chk("t1_tmo",   32'(if0.timeout), 32'd0);
        chk("t1_fvld",  32'(if0.first_err_vld), 32'd0);
        smp(1'b1, 1'b1, 1'b0);
        chk("t1_hold_err", 32'(if0.err_cnt), 32'd0);
        chk("t1_hold_done", 32'(if0.done), 32'd1);

        // AND with y stuck low at 11
        pulse_start();
        chk("t2_clr_pass", 32'(if0.pass), 32'd0);
        chk("t2_clr_cov",  32'(if0.cov), 32'd0);
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        smp(1'b1, 1'b0, 1'b0);
        smp(1'b1, 1'b1, 1'b0);
        chk("t2_done", 32'(if0.done), 32'd1);
        chk("t2_pass", 32'(if0.pass), 32'd0);
        chk("t2_err",  32'(if0.err_cnt), 32'd1);
        chk("t2_fvld", 32'(if0.first_err_vld), 32'd1);
        chk("t2_fvec", 32'(if0.first_err_vec), 32'b110);

        // Incomplete coverage runs into the 16-cycle timeout
        pulse_start();
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        smp(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        chk("t3_busy_pre", 32'(if0.busy), 32'd1);
        chk("t3_done_pre", 32'(if0.done), 32'd0);
        tick();
        chk("t3_done", 32'(if0.done), 32'd1);
        chk("t3_tmo",  32'(if0.timeout), 32'd1);
        chk("t3_cov",  32'(if0.cov), 32'h7);
        chk("t3_pass", 32'(if0.pass), 32'd0);

        // Inverted XOR, 2-bit counter saturates; no timeout when disabled
        pulse_start();
        for (int i = 0; i < 40; i++) tick();
        chk("t4_notmo_busy", 32'(if1.busy), 32'd1);
        pulse_start();
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        smp(1'b1, 1'b0, 1'b0);
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        chk("t4_err5",  32'(if1.err_cnt), 32'd3);
        chk("t4_busy5", 32'(if1.busy), 32'd1);
        smp(1'b1, 1'b1, 1'b0);
        chk("t4_done", 32'(if1.done), 32'd1);
        chk("t4_err",  32'(if1.err_cnt), 32'd3);
        chk("t4_pass", 32'(if1.pass), 32'd0);
        chk("t4_fvec", 32'(if1.first_err_vec), 32'b001);
        chk("t4_cov",  32'(if1.cov), 32'hF);
        chk("t4_tmo",  32'(if1.timeout), 32'd0);

        // Asynchronous reset mid-run
        pulse_start();
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b1, 1'b1, 1'b0);
        chk("t5_err_pre", 32'(if0.err_cnt), 32'd1);
        rst = 1'b1;
        #2;
        chk("t5_busy", 32'(if0.busy), 32'd0);
        chk("t5_cov",  32'(if0.cov), 32'd0);
        chk("t5_err",  32'(if0.err_cnt), 32'd0);
        chk("t5_fvld", 32'(if0.first_err_vld), 32'd0);
        #1 rst = 1'b0;
        pulse_start();
        smp(1'b1, 1'b1, 1'b1);
        smp(1'b1, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        smp(1'b0, 1'b0, 1'b0);
        chk("t5_done", 32'(if0.done), 32'd1);
        chk("t5_pass", 32'(if0.pass), 32'd1);

        // Restart while running; the concurrent sample must be dropped
        pulse_start();
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b1);
        smp(1'b1, 1'b0, 1'b0);
        chk("t6_err_pre", 32'(if0.err_cnt), 32'd1);
        a         = 1'b1;
        b         = 1'b1;
        y         = 1'b1;
        smp_valid = 1'b1;
        pulse_start();
        smp_valid = 1'b0;
        chk("t6_err",  32'(if0.err_cnt), 32'd0);
        chk("t6_cov",  32'(if0.cov), 32'd0);
        chk("t6_fvld", 32'(if0.first_err_vld), 32'd0);
        chk("t6_busy", 32'(if0.busy), 32'd1);
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b1, 1'b0);
        smp(1'b1, 1'b0, 1'b0);
        smp(1'b1, 1'b1, 1'b1);
        chk("t6_done", 32'(if0.done), 32'd1);
        chk("t6_pass", 32'(if0.pass), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
